// File: rtl/cell_comm_pkg.sv
// Shared types, constants and helpers for the cell-comm packet arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cell_comm_pkg;

  localparam logic [15:0] HEADER_MAGIC_DEF = 16'hA5BE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOC     = 3'd1,
    ST_FW      = 3'd2,
    ST_TERM    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  // The invalid marker on a watchdog terminator is the word MSB.
  function automatic int invalid_mark_bit(input int dw);
    return dw - 1;
  endfunction

  // Header word: magic in the top 16 bits, zero pad, FOFB index in the LSBs.
  // Built 64 bits wide; callers truncate to their data width.
  function automatic logic [63:0] build_header(input logic [15:0] magic,
                                               input logic [15:0] idx,
                                               input int          dw);
    logic [63:0] hdr;
    hdr = {48'h0, idx};
    hdr = hdr | ({48'h0, magic} << (dw - 16));
    return hdr;
  endfunction

endpackage

// File: rtl/cell_comm_loc_serializer.sv
// Snapshot register and beat sequencer for the locally generated FA packet.
// Latency: header registered on the cycle after i_start; one beat per i_advance.
// Backpressure: o_data/o_last hold until i_advance; snapshot is independent of the beat in flight.
module cell_comm_loc_serializer
  import cell_comm_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          FOFB_IDX_WIDTH = 9,
  parameter int          NUM_WORDS      = 3,
  parameter logic [15:0] HEADER_MAGIC   = HEADER_MAGIC_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_capture,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] i_loc_data,
  input  logic                            i_clip,
  input  logic [FOFB_IDX_WIDTH-1:0]       i_index,
  input  logic                            i_start,
  input  logic                            i_advance,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_last
);

  localparam int BEAT_W = $clog2(NUM_WORDS + 1);
  localparam int PAY_W  = NUM_WORDS * DATA_WIDTH;

  logic [PAY_W-1:0]          r_snap_words;
  logic                      r_snap_clip;
  logic [FOFB_IDX_WIDTH-1:0] r_snap_idx;
  logic [PAY_W-1:0]          r_pkt_words;
  logic                      r_pkt_clip;
  logic [BEAT_W-1:0]         r_beat;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [BEAT_W-1:0]         w_sel;
  logic [DATA_WIDTH-1:0]     w_raw_word;
  logic [DATA_WIDTH-1:0]     w_next_word;

  // Snapshot of the strobe-time inputs; the top only asserts capture when nothing is pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap_words <= '0;
      r_snap_clip  <= 1'b0;
      r_snap_idx   <= '0;
    end else if (i_capture) begin
      r_snap_words <= i_loc_data;
      r_snap_clip  <= i_clip;
      r_snap_idx   <= i_index;
    end
  end

  // Next payload word; the final word carries the clip flag below a cleared MSB.
  always_comb begin
    w_sel       = (int'(r_beat) < NUM_WORDS) ? r_beat : '0;
    w_raw_word  = r_pkt_words[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    w_next_word = w_raw_word;
    if (int'(r_beat) == NUM_WORDS - 1) begin
      w_next_word = {1'b0, r_pkt_clip, w_raw_word[DATA_WIDTH-3:0]};
    end
  end

  // Packet copy and beat register: a strobe arriving mid-packet cannot disturb the words being sent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_words <= '0;
      r_pkt_clip  <= 1'b0;
      r_beat      <= '0;
      r_data      <= '0;
    end else if (i_start) begin
      r_pkt_words <= r_snap_words;
      r_pkt_clip  <= r_snap_clip;
      r_beat      <= '0;
      r_data      <= DATA_WIDTH'(build_header(HEADER_MAGIC, 16'(r_snap_idx), DATA_WIDTH));
    end else if (i_advance && (r_beat != BEAT_W'(NUM_WORDS))) begin
      r_beat <= r_beat + BEAT_W'(1);
      r_data <= w_next_word;
    end
  end

  assign o_data = r_data;
  assign o_last = (r_beat == BEAT_W'(NUM_WORDS));

endmodule

// File: rtl/cell_comm_packet_arbiter.sv
// Merges the local FA packet with forwarded rx packets onto one tx stream, switching at packet boundaries.
// Latency: local header 2 cycles after the strobe; forward path is combinational pass-through.
// Backpressure: honours txReady; stalled forwards are cut by a watchdog with an invalid-marked terminator.
module cell_comm_packet_arbiter
  import cell_comm_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          FOFB_IDX_WIDTH = 9,
  parameter int          NUM_WORDS      = 3,
  parameter int          WDOG_WIDTH     = 6,
  parameter logic [15:0] HEADER_MAGIC   = HEADER_MAGIC_DEF
) (
  input  logic                            txClk,
  input  logic                            txReset,
  input  logic                            txFaStrobe,
  input  logic                            txIsClipping,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] txLocData,
  input  logic                            txFOFBvalid,
  input  logic [FOFB_IDX_WIDTH-1:0]       txFOFBindex,
  input  logic                            txAuroraChannelUp,
  input  logic                            txFwValid,
  input  logic                            txFwLast,
  input  logic [DATA_WIDTH-1:0]           txFwData,
  output logic                            txFwReady,
  output logic                            txValid,
  output logic                            txLast,
  output logic [DATA_WIDTH-1:0]           txData,
  input  logic                            txReady,
  output logic [15:0]                     txLocOverrunCount,
  output logic [15:0]                     txFwTimeoutCount
);

  localparam int INV_BIT = invalid_mark_bit(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_pending;
  logic [WDOG_WIDTH-1:0] r_wdog;
  logic [15:0]           r_loc_overrun;
  logic [15:0]           r_fw_timeout;
  logic                  w_capture;
  logic                  w_loc_start;
  logic                  w_loc_adv;
  logic                  w_fw_acc;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_ser_data;
  logic                  w_ser_last;

  assign w_capture = txFaStrobe && !r_pending;

  cell_comm_loc_serializer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .FOFB_IDX_WIDTH(FOFB_IDX_WIDTH),
    .NUM_WORDS     (NUM_WORDS),
    .HEADER_MAGIC  (HEADER_MAGIC)
  ) u_loc_ser (
    .i_clk     (txClk),
    .i_rst     (txReset),
    .i_capture (w_capture),
    .i_loc_data(txLocData),
    .i_clip    (txIsClipping),
    .i_index   (txFOFBindex),
    .i_start   (w_loc_start),
    .i_advance (w_loc_adv),
    .o_data    (w_ser_data),
    .o_last    (w_ser_last)
  );

  // State register.
  always_ff @(posedge txClk) begin
    if (txReset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and output mux; a dropped link forces IDLE and hides any beat in flight.
  always_comb begin
    w_state_nxt = r_state;
    txValid     = 1'b0;
    txLast      = 1'b0;
    txData      = '0;
    txFwReady   = 1'b0;
    w_loc_start = 1'b0;
    w_loc_adv   = 1'b0;
    w_fw_acc    = 1'b0;
    w_timeout   = 1'b0;
    if (!txAuroraChannelUp) begin
      txFwReady   = (r_state == ST_IDLE);
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            if (txFOFBvalid) begin
              w_loc_start = 1'b1;
              w_state_nxt = ST_LOC;
            end
          end else if (txFwValid) begin
            w_state_nxt = ST_FW;
          end
        end
        ST_LOC: begin
          txValid = 1'b1;
          txData  = w_ser_data;
          txLast  = w_ser_last;
          if (txReady) begin
            w_loc_adv = 1'b1;
            if (w_ser_last) w_state_nxt = ST_IDLE;
          end
        end
        ST_FW: begin
          txValid   = txFwValid;
          txData    = txFwData;
          txLast    = txFwLast;
          txFwReady = txReady;
          w_fw_acc  = txFwValid && txReady;
          if (w_fw_acc) begin
            if (txFwLast) w_state_nxt = ST_IDLE;
          end else if (r_wdog == '0) begin
            w_timeout   = 1'b1;
            w_state_nxt = ST_TERM;
          end
        end
        ST_TERM: begin
          txValid          = 1'b1;
          txData[INV_BIT]  = 1'b1;
          txLast           = 1'b1;
          if (txReady) w_state_nxt = ST_DISCARD;
        end
        ST_DISCARD: begin
          txFwReady = 1'b1;
          if (txFwValid && txFwLast) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Pending flag: set by a strobe, consumed (sent or dropped) on the first IDLE cycle.
  always_ff @(posedge txClk) begin
    if (txReset)                 r_pending <= 1'b0;
    else if (w_capture)          r_pending <= 1'b1;
    else if (r_state == ST_IDLE) r_pending <= 1'b0;
  end

  // Forward watchdog: held full outside FW and on each accepted beat, counts down on idle FW cycles.
  always_ff @(posedge txClk) begin
    if (txReset)                          r_wdog <= '1;
    else if (r_state != ST_FW || w_fw_acc) r_wdog <= '1;
    else if (r_wdog != '0)                 r_wdog <= r_wdog - WDOG_WIDTH'(1);
  end

  // Saturating status counters.
  always_ff @(posedge txClk) begin
    if (txReset) begin
      r_loc_overrun <= '0;
      r_fw_timeout  <= '0;
    end else begin
      if (txFaStrobe && r_pending && (r_loc_overrun != 16'hFFFF))
        r_loc_overrun <= r_loc_overrun + 16'd1;
      if (w_timeout && (r_fw_timeout != 16'hFFFF))
        r_fw_timeout <= r_fw_timeout + 16'd1;
    end
  end

  assign txLocOverrunCount = r_loc_overrun;
  assign txFwTimeoutCount  = r_fw_timeout;

endmodule

// File: tb/tb_cell_comm_packet_arbiter.sv
// Scoreboard bench for the cell-comm packet arbiter: directed packets, forward timeouts, link loss, reset.
// Latency: checks local header two cycles after the strobe.
// Backpressure: drives txReady stalls and checks data held against the expected beat.
module tb_cell_comm_packet_arbiter;

  localparam int DW = 32;
  localparam int IW = 9;
  localparam int NW = 3;
  localparam int WW = 6;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic              txClk = 1'b0;
  logic              txReset;
  logic              txFaStrobe;
  logic              txIsClipping;
  logic [NW*DW-1:0]  txLocData;
  logic              txFOFBvalid;
  logic [IW-1:0]     txFOFBindex;
  logic              txAuroraChannelUp;
  logic              txFwValid;
  logic              txFwLast;
  logic [DW-1:0]     txFwData;
  logic              txFwReady;
  logic              txValid;
  logic              txLast;
  logic [DW-1:0]     txData;
  logic              txReady;
  logic [15:0]       txLocOverrunCount;
  logic [15:0]       txFwTimeoutCount;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 txClk = ~txClk;

  cell_comm_packet_arbiter #(
    .DATA_WIDTH(DW), .FOFB_IDX_WIDTH(IW), .NUM_WORDS(NW), .WDOG_WIDTH(WW), .HEADER_MAGIC(16'hA5BE)
  ) dut (
    .txClk            (txClk),
    .txReset          (txReset),
    .txFaStrobe       (txFaStrobe),
    .txIsClipping     (txIsClipping),
    .txLocData        (txLocData),
    .txFOFBvalid      (txFOFBvalid),
    .txFOFBindex      (txFOFBindex),
    .txAuroraChannelUp(txAuroraChannelUp),
    .txFwValid        (txFwValid),
    .txFwLast         (txFwLast),
    .txFwData         (txFwData),
    .txFwReady        (txFwReady),
    .txValid          (txValid),
    .txLast           (txLast),
    .txData           (txData),
    .txReady          (txReady),
    .txLocOverrunCount(txLocOverrunCount),
    .txFwTimeoutCount (txFwTimeoutCount)
  );

  task automatic tick();
    @(posedge txClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic strobe(input logic [IW-1:0] idx, input logic [NW*DW-1:0] words, input logic clip);
    txFOFBindex  = idx;
    txLocData    = words;
    txIsClipping = clip;
    txFaStrobe   = 1'b1;
    tick();
    txFaStrobe   = 1'b0;
  endtask

  task automatic fw_send(input logic [31:0] d, input logic l);
    bit acc;
    int budget;
    txFwValid = 1'b1;
    txFwData  = d;
    txFwLast  = l;
    acc       = 1'b0;
    budget    = 0;
    while (!acc && budget < 200) begin
      @(negedge txClk);
      acc = txFwReady;
      tick();
      budget++;
    end
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL fw_send: beat 0x%08h not accepted, required acceptance within 200 cycles", d);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d beats still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    txReset = 1'b1; txFaStrobe = 1'b0; txIsClipping = 1'b0; txLocData = '0;
    txFOFBvalid = 1'b1; txFOFBindex = '0; txAuroraChannelUp = 1'b1;
    txFwValid = 1'b0; txFwLast = 1'b0; txFwData = '0; txReady = 1'b1;

    // Output monitor: pops the scoreboard on every handshake, checks held data on stalls.
    fork
      forever begin
        @(negedge txClk);
        if (!txReset && txValid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data 0x%08h last %0b, required no beat", txData, txLast);
          end else if (txReady) begin
            mon_b = exp_q.pop_front();
            chk("beat_data", txData, mon_b.d);
            chk("beat_last", {31'b0, txLast}, {31'b0, mon_b.l});
          end else begin
            chk("stall_hold", txData, exp_q[0].d);
          end
        end
      end
    join_none

    // Reset state.
    tick(); tick();
    chk("rst_valid", {31'b0, txValid}, 32'h0);
    chk("rst_last", {31'b0, txLast}, 32'h0);
    chk("rst_data", txData, 32'h0);
    chk("rst_fwready", {31'b0, txFwReady}, 32'h0);
    chk("rst_overrun", {16'h0, txLocOverrunCount}, 32'h0);
    chk("rst_timeout", {16'h0, txFwTimeoutCount}, 32'h0);
    txReset = 1'b0;
    tick();

    // 1: basic local packet and its latency.
    push(32'hA5BE005A, 1'b0); push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0); push(32'h73333333, 1'b1);
    strobe(9'h05A, {32'hF3333333, 32'h22222222, 32'h11111111}, 1'b1);
    chk("t1_pending_no_valid", {31'b0, txValid}, 32'h0);
    tick();
    chk("t1_hdr_valid", {31'b0, txValid}, 32'h1);
    chk("t1_hdr_data", txData, 32'hA5BE005A);
    wait_drain("t1_drain", 50);

    // 2: local packet under toggling backpressure.
    push(32'hA5BE01FF, 1'b0); push(32'hDEADBEEF, 1'b0);
    push(32'h01234567, 1'b0); push(32'h0AFEF00D, 1'b1);
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          txReady = ~txReady;
          tick();
        end
      end
      begin
        strobe(9'h1FF, {32'hCAFEF00D, 32'h01234567, 32'hDEADBEEF}, 1'b0);
        wait_drain("t2_drain", 100);
      end
    join
    txReady = 1'b1;
    tick();

    // 3: forward packet with a strobe mid-packet; local packet follows intact.
    for (int i = 1; i <= 5; i++) push(32'hF0000000 | 32'(i), (i == 5));
    fork
      begin
        for (int i = 1; i <= 5; i++) fw_send(32'hF0000000 | 32'(i), (i == 5));
        txFwValid = 1'b0; txFwLast = 1'b0;
      end
      begin
        repeat (3) tick();
        push(32'hA5BE0003, 1'b0); push(32'h0000000A, 1'b0);
        push(32'h0000000B, 1'b0); push(32'h4000000C, 1'b1);
        strobe(9'h003, {32'h0000000C, 32'h0000000B, 32'h0000000A}, 1'b1);
      end
    join
    wait_drain("t3_drain", 100);

    // 4: forward stalls after two beats; watchdog terminates, remainder discarded.
    push(32'h0BAD0001, 1'b0); push(32'h0BAD0002, 1'b0); push(32'h80000000, 1'b1);
    fw_send(32'h0BAD0001, 1'b0);
    fw_send(32'h0BAD0002, 1'b0);
    txFwValid = 1'b0;
    wait_drain("t4_term", 200);
    fw_send(32'h0BAD0003, 1'b0);
    fw_send(32'h0BAD0004, 1'b0);
    fw_send(32'h0BAD0005, 1'b1);
    txFwValid = 1'b0; txFwLast = 1'b0;
    tick(); tick();
    chk("t4_timeout_cnt", {16'h0, txFwTimeoutCount}, 32'h1);
    chk("t4_idle_after_discard", {31'b0, txValid}, 32'h0);

    // 5: overrun strobes while the link is down; no packet, forward data flushed.
    txAuroraChannelUp = 1'b0; txFOFBvalid = 1'b0;
    tick();
    txFOFBindex = 9'h0AA; txLocData = '1; txFaStrobe = 1'b1;
    tick(); tick();
    txFaStrobe = 1'b0;
    chk("t5_overrun_cnt", {16'h0, txLocOverrunCount}, 32'h1);
    txFwValid = 1'b1; txFwData = 32'h5EED0001; txFwLast = 1'b0;
    #1;
    chk("t5_flush_ready", {31'b0, txFwReady}, 32'h1);
    chk("t5_no_valid", {31'b0, txValid}, 32'h0);
    tick(); tick();
    txFwLast = 1'b1;
    tick();
    txFwValid = 1'b0; txFwLast = 1'b0;
    txAuroraChannelUp = 1'b1; txFOFBvalid = 1'b1;
    repeat (4) tick();
    chk("t5_no_packet", {31'b0, txValid}, 32'h0);
    chk("t5_fwready_up", {31'b0, txFwReady}, 32'h0);

    // 6: reset mid-packet, then a clean packet.
    push(32'hA5BE0077, 1'b0); push(32'h00000001, 1'b0);
    push(32'h00000002, 1'b0); push(32'h00000003, 1'b1);
    strobe(9'h077, {32'h00000003, 32'h00000002, 32'h00000001}, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() > 2; k++) tick();
    txReset = 1'b1;
    txReady = 1'b0;
    exp_q.delete();
    tick();
    chk("t6_valid_after_rst", {31'b0, txValid}, 32'h0);
    chk("t6_overrun_rst", {16'h0, txLocOverrunCount}, 32'h0);
    chk("t6_timeout_rst", {16'h0, txFwTimeoutCount}, 32'h0);
    txReset = 1'b0;
    txReady = 1'b1;
    tick();
    push(32'hA5BE0100, 1'b0); push(32'h55555555, 1'b0);
    push(32'h66666666, 1'b0); push(32'h7FFFFFFF, 1'b1);
    strobe(9'h100, {32'hFFFFFFFF, 32'h66666666, 32'h55555555}, 1'b1);
    wait_drain("t6_drain", 50);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
